data_memory_bytelane: RTL and testbench

//  Parametrised byte-addressed data memory for the pipeline MEM stage.

---
 rtl/data_memory_bytelane_pkg.sv | 31 +++
 rtl/data_memory_bytelane_lsu_load_extend.sv | 27 ++
 rtl/data_memory_bytelane.sv | 138 +++++++++++++
 tb/tb_data_memory_bytelane.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/data_memory_bytelane_pkg.sv
// Shared types for the byte-lane data memory: access sizes, error codes,
// FSM states and byte-enable patterns.
package data_memory_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } mem_err_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

    localparam int         LANES   = 4;
    localparam int         LANE_W  = 8;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/data_memory_bytelane_lsu_load_extend.sv
// Load lane selection with sign or zero extension; purely combinational.
module lsu_load_extend
    import data_memory_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = word >> {off, 3'b000};

    always_comb begin
        data = '0;
        case (size)
            SZ_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            SZ_W:    data = word;
            SZ_BU:   data = {24'b0, shifted[7:0]};
            SZ_HU:   data = {16'b0, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-addressed data memory for the MEM stage: byte-enable stores, extended
// loads with one-cycle registered response, error detection, clear-after-reset.
module data_memory_bytelane
    import data_memory_pkg::*;
#(
    parameter int DEPTH           = 256,
    parameter int ADDR_WIDTH      = 32,
    parameter bit CLEAR_ON_RESET  = 1'b1,
    parameter bit ZERO_WORD_GUARD = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           write_data,
    output logic                  rsp_valid,
    output logic [31:0]           read_data,
    output logic [1:0]            err_code
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    mem_state_e       state, state_nxt;
    logic [IDX_W-1:0] clr_idx;
    logic [IDX_W-1:0] word;
    logic [1:0]       off;
    logic             accept, illegal, out_range, misaligned;
    logic             clr_we, st_we, guarded;
    mem_err_e         err;
    logic [3:0]       be;
    logic [31:0]      wdata_rep, ld_ext;

    assign word      = addr[IDX_W+1:2];
    assign off       = addr[1:0];
    assign accept    = req_valid && req_ready;
    assign out_range = (addr >> (IDX_W + 2)) != '0;
    assign guarded   = ZERO_WORD_GUARD && (word == '0);

    // FSM: CLEAR walks the array once, READY accepts one request per cycle.
    always_ff @(posedge clock) begin
        if (reset) state <= ST_CLEAR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (!CLEAR_ON_RESET || clr_idx == IDX_W'(DEPTH - 1))
                    state_nxt = ST_READY;
            end
            ST_READY: req_ready = !reset;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)                  clr_idx <= '0;
        else if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
    end

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (req_size)
            SZ_B:  ;
            SZ_H:  misaligned = off[0];
            SZ_W:  misaligned = (off != 2'b00);
            SZ_BU: illegal    = req_write;
            SZ_HU: begin
                illegal    = req_write;
                misaligned = off[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        err = ERR_OK;
        if (illegal)         err = ERR_ILLEGAL;
        else if (out_range)  err = ERR_RANGE;
        else if (misaligned) err = ERR_MISALIGN;
    end

    // Store data is replicated across lanes so the enables alone pick the bytes.
    always_comb begin
        be        = BE_WORD;
        wdata_rep = write_data;
        case (req_size)
            SZ_B: begin
                be        = BE_BYTE << off;
                wdata_rep = {4{write_data[7:0]}};
            end
            SZ_H: begin
                be        = BE_HALF << off;
                wdata_rep = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign clr_we = CLEAR_ON_RESET && (state == ST_CLEAR) && !reset;
    assign st_we  = accept && req_write && (err == ERR_OK) && !guarded;

    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (st_we) begin
            for (int b = 0; b < LANES; b++)
                if (be[b]) mem[word][LANE_W*b +: LANE_W] <= wdata_rep[LANE_W*b +: LANE_W];
        end
    end

    lsu_load_extend u_ext (
        .word (mem[word]),
        .off  (off),
        .size (req_size),
        .data (ld_ext)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            read_data <= '0;
            err_code  <= ERR_OK;
        end else begin
            rsp_valid <= accept;
            err_code  <= accept ? err : ERR_OK;
            read_data <= (accept && !req_write && err == ERR_OK) ? ld_ext : '0;
        end
    end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed bench for data_memory_bytelane: vector table plus reset/clear and
// back-to-back sequences.
module tb_data_memory_bytelane;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        rsp_valid;
    logic [31:0] read_data;
    logic [1:0]  err_code;

    int total = 0;
    int bad   = 0;

    data_memory_bytelane #(
        .DEPTH(256), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1'b1), .ZERO_WORD_GUARD(1'b1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .addr       (addr),
        .write_data (write_data),
        .rsp_valid  (rsp_valid),
        .read_data  (read_data),
        .err_code   (err_code)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ed;
        logic [1:0]  ee;
    } vec_t;

    vec_t vt[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [2:0] s, input logic [31:0] a,
                          input logic [31:0] d, output logic rv, output logic [31:0] rd,
                          output logic [1:0] er);
        int n = 0;
        while (req_ready !== 1'b1 && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_size = s; addr = a; write_data = d;
        @(posedge clock); #1;
        req_valid = 1'b0;
        rv = rsp_valid; rd = read_data; er = err_code;
    endtask

    task automatic wait_clear(input string name);
        int cnt = 0;
        while (req_ready !== 1'b1 && cnt < 1000) begin
            cnt++;
            @(posedge clock); #1;
        end
        chk(name, cnt, 32'd256);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        rv;
        logic [31:0] rd;
        logic [1:0]  er;

        vt[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        2'b00};
        vt[1]  = '{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 2'b00};
        vt[2]  = '{1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 2'b00};
        vt[3]  = '{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 2'b00};
        vt[4]  = '{1'b0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 2'b00};
        vt[5]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 2'b00};
        vt[6]  = '{1'b0, 3'b000, 32'h10,  32'h0,        32'hFFFFFFEF, 2'b00};
        vt[7]  = '{1'b0, 3'b100, 32'h11,  32'h0,        32'h000000BE, 2'b00};
        vt[8]  = '{1'b1, 3'b000, 32'h21,  32'hAAAAAA55, 32'h0,        2'b00};
        vt[9]  = '{1'b0, 3'b010, 32'h20,  32'h0,        32'h00005500, 2'b00};
        vt[10] = '{1'b1, 3'b001, 32'h22,  32'hFFFF1234, 32'h0,        2'b00};
        vt[11] = '{1'b0, 3'b010, 32'h20,  32'h0,        32'h12345500, 2'b00};
        vt[12] = '{1'b0, 3'b010, 32'h06,  32'h0,        32'h0,        2'b01};
        vt[13] = '{1'b1, 3'b010, 32'h440, 32'h11111111, 32'h0,        2'b10};
        vt[14] = '{1'b0, 3'b010, 32'h40,  32'h0,        32'h0,        2'b00};
        vt[15] = '{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        2'b11};
        vt[16] = '{1'b1, 3'b101, 32'h10,  32'h0000FFFF, 32'h0,        2'b11};
        vt[17] = '{1'b0, 3'b110, 32'h401, 32'h0,        32'h0,        2'b11};
        vt[18] = '{1'b0, 3'b001, 32'h401, 32'h0,        32'h0,        2'b10};
        vt[19] = '{1'b1, 3'b010, 32'h22,  32'h77777777, 32'h0,        2'b01};
        vt[20] = '{1'b0, 3'b010, 32'h20,  32'h0,        32'h12345500, 2'b00};
        vt[21] = '{1'b1, 3'b010, 32'h0,   32'hFFFFFFFF, 32'h0,        2'b00};
        vt[22] = '{1'b0, 3'b010, 32'h0,   32'h0,        32'h0,        2'b00};
        vt[23] = '{1'b0, 3'b101, 32'h23,  32'h0,        32'h0,        2'b01};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 3'b010;
        addr = '0; write_data = '0;

        // Single reset edge, then the full clear walk.
        @(posedge clock); #1;
        chk("reset_ready", {31'b0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_err", {30'b0, err_code}, 32'd0);
        reset = 1'b0;
        #1;
        wait_clear("clear_cycles");

        for (int i = 0; i < 256; i++) begin
            do_req(1'b0, 3'b010, i * 4, 32'h0, rv, rd, er);
            if (rv !== 1'b1 || rd !== 32'h0 || er !== 2'b00)
                chk($sformatf("cleared_word_%0d", i), {rv, 1'b0, er, rd[27:0]}, 32'h80000000);
            else
                chk($sformatf("cleared_word_%0d", i), rd, 32'h0);
        end

        for (int i = 0; i < 24; i++) begin
            do_req(vt[i].wr, vt[i].sz, vt[i].a, vt[i].wd, rv, rd, er);
            chk($sformatf("vec%0d_valid", i), {31'b0, rv}, 32'd1);
            chk($sformatf("vec%0d_data", i), rd, vt[i].ed);
            chk($sformatf("vec%0d_err", i), {30'b0, er}, {30'b0, vt[i].ee});
        end

        // Idle cycle after a response: no pulse, data held at zero.
        @(posedge clock); #1;
        chk("idle_valid", {31'b0, rsp_valid}, 32'd0);
        chk("idle_data", read_data, 32'h0);

        // Store then load of the same word on consecutive cycles.
        req_valid = 1'b1; req_write = 1'b1; req_size = 3'b010;
        addr = 32'h30; write_data = 32'hCAFEF00D;
        @(posedge clock); #1;
        chk("b2b_sw_valid", {31'b0, rsp_valid}, 32'd1);
        chk("b2b_sw_data", read_data, 32'h0);
        req_write = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("b2b_lw_valid", {31'b0, rsp_valid}, 32'd1);
        chk("b2b_lw_data", read_data, 32'hCAFEF00D);
        @(posedge clock); #1;
        chk("b2b_idle_valid", {31'b0, rsp_valid}, 32'd0);

        // Reset coincides with a load accept: the response is dropped.
        req_valid = 1'b1; req_write = 1'b0; req_size = 3'b010; addr = 32'h30;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_load_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_load_data", read_data, 32'h0);
        reset = 1'b0; req_valid = 1'b0;
        #1;
        wait_clear("clear_after_load_reset");
        do_req(1'b0, 3'b010, 32'h30, 32'h0, rv, rd, er);
        chk("cleared_0x30", rd, 32'h0);

        // Reset in the middle of the clear walk restarts it from index 0.
        do_req(1'b1, 3'b010, 32'h3FC, 32'h5A5A5A5A, rv, rd, er);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        chk("mid_clear_ready", {31'b0, req_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        wait_clear("clear_restart");
        do_req(1'b0, 3'b010, 32'h3FC, 32'h0, rv, rd, er);
        chk("cleared_last_word", rd, 32'h0);
        chk("cleared_last_valid", {31'b0, rv}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
